// File: rtl/alu_issue_unit_pkg.sv
// Shared definitions for the ALU issue path: operation codes, request types,
// issue FSM states and branch-condition selects.
package alu_issue_unit_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_NOR  = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        OPT_MEM    = 2'b00,
        OPT_BRANCH = 2'b01,
        OPT_RTYPE  = 2'b10,
        OPT_ITYPE  = 2'b11
    } alu_op_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LT   = 3'd3,
        BR_GE   = 3'd4
    } br_sel_e;

    // LT/GE cover both signed and unsigned compares: the ALU's SLT/SLTU
    // result lands in bit 0.
    function automatic logic branch_eval(input br_sel_e sel, input logic zr, input logic lsb);
        case (sel)
            BR_EQ:   branch_eval = zr;
            BR_NE:   branch_eval = !zr;
            BR_LT:   branch_eval = lsb;
            BR_GE:   branch_eval = !lsb;
            default: branch_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_unit_func_decoder.sv
// Combinational decode of (op type, funct3, funct7 bit 5) into the ALU
// operation code, an illegal flag and the branch-condition select.
module alu_func_decoder
    import alu_issue_unit_pkg::*;
(
    input  logic [1:0] alu_op_type,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_operation,
    output logic       illegal,
    output br_sel_e    br_sel
);

    alu_op_e op;
    logic    is_itype;

    assign alu_operation = op;
    assign is_itype      = (alu_op_type == OPT_ITYPE);

    always_comb begin
        op      = ALU_AND;
        illegal = 1'b0;
        br_sel  = BR_NONE;
        case (alu_op_type_e'(alu_op_type))
            OPT_MEM: op = ALU_ADD;
            OPT_BRANCH: begin
                case (funct3)
                    3'b000:  begin op = ALU_SUB;  br_sel = BR_EQ; end
                    3'b001:  begin op = ALU_SUB;  br_sel = BR_NE; end
                    3'b100:  begin op = ALU_SLT;  br_sel = BR_LT; end
                    3'b101:  begin op = ALU_SLT;  br_sel = BR_GE; end
                    3'b110:  begin op = ALU_SLTU; br_sel = BR_LT; end
                    3'b111:  begin op = ALU_SLTU; br_sel = BR_GE; end
                    default: illegal = 1'b1;
                endcase
            end
            default: begin
                // R-type and I-type share the table; I-type ignores funct7_5
                // everywhere except the shift-right pair.
                case (funct3)
                    3'b000:  op = (funct7_5 && !is_itype) ? ALU_SUB : ALU_ADD;
                    3'b001:  op = ALU_SLL;
                    3'b010:  op = ALU_SLT;
                    3'b011:  op = ALU_SLTU;
                    3'b100:  op = ALU_XOR;
                    3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  op = ALU_OR;
                    default: op = ALU_AND;
                endcase
                if (!is_itype && funct7_5 && funct3 != 3'b000 && funct3 != 3'b101) begin
                    illegal = 1'b1;
                    op      = ALU_AND;
                end
            end
        endcase
        if (illegal) begin
            br_sel = BR_NONE;
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue side of the ALU: takes a decoded request, drives the combinational
// ALU for one cycle, captures its result and returns it with a branch verdict.
module alu_issue_unit
    import alu_issue_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op_type,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [3:0]      alu_operation,
    output logic [XLEN-1:0] alu_in_x,
    output logic [XLEN-1:0] alu_in_y,
    input  logic [XLEN-1:0] alu_out_s,
    input  logic            alu_zr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch_taken,
    output logic            illegal
);

    state_e          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [3:0]      alu_operation_q, alu_operation_d;
    logic [XLEN-1:0] alu_in_x_q, alu_in_x_d;
    logic [XLEN-1:0] alu_in_y_q, alu_in_y_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            branch_taken_q, branch_taken_d;
    logic            illegal_q, illegal_d;
    br_sel_e         br_sel_q, br_sel_d;

    logic [3:0]      dec_operation;
    logic            dec_illegal;
    br_sel_e         dec_br_sel;

    alu_func_decoder u_decoder (
        .alu_op_type   (alu_op_type),
        .funct3        (funct3),
        .funct7_5      (funct7_5),
        .alu_operation (dec_operation),
        .illegal       (dec_illegal),
        .br_sel        (dec_br_sel)
    );

    always_comb begin
        state_d         = state_q;
        in_ready_d      = in_ready_q;
        out_valid_d     = out_valid_q;
        alu_operation_d = alu_operation_q;
        alu_in_x_d      = alu_in_x_q;
        alu_in_y_d      = alu_in_y_q;
        result_d        = result_q;
        branch_taken_d  = branch_taken_q;
        illegal_d       = illegal_q;
        br_sel_d        = br_sel_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    alu_operation_d = dec_operation;
                    alu_in_x_d      = op_a;
                    alu_in_y_d      = op_b;
                    illegal_d       = dec_illegal;
                    br_sel_d        = dec_br_sel;
                    in_ready_d      = 1'b0;
                    state_d         = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Illegal requests still complete, but report a neutral result.
                result_d       = illegal_q ? '0 : alu_out_s;
                branch_taken_d = illegal_q ? 1'b0 : branch_eval(br_sel_q, alu_zr, alu_out_s[0]);
                out_valid_d    = 1'b1;
                state_d        = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            in_ready_q      <= 1'b1;
            out_valid_q     <= 1'b0;
            alu_operation_q <= '0;
            alu_in_x_q      <= '0;
            alu_in_y_q      <= '0;
            result_q        <= '0;
            branch_taken_q  <= 1'b0;
            illegal_q       <= 1'b0;
            br_sel_q        <= BR_NONE;
        end else begin
            state_q         <= state_d;
            in_ready_q      <= in_ready_d;
            out_valid_q     <= out_valid_d;
            alu_operation_q <= alu_operation_d;
            alu_in_x_q      <= alu_in_x_d;
            alu_in_y_q      <= alu_in_y_d;
            result_q        <= result_d;
            branch_taken_q  <= branch_taken_d;
            illegal_q       <= illegal_d;
            br_sel_q        <= br_sel_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign alu_operation = alu_operation_q;
    assign alu_in_x      = alu_in_x_q;
    assign alu_in_y      = alu_in_y_q;
    assign result        = result_q;
    assign branch_taken  = branch_taken_q;
    assign illegal       = illegal_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural combinational ALU
// attached to the issue outputs.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  alu_op_type = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic        funct7_5 = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [3:0]  alu_operation;
    logic [31:0] alu_in_x;
    logic [31:0] alu_in_y;
    logic [31:0] alu_out_s;
    logic        alu_zr;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        branch_taken;
    logic        illegal;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    alu_issue_unit #(.XLEN(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_op_type   (alu_op_type),
        .funct3        (funct3),
        .funct7_5      (funct7_5),
        .op_a          (op_a),
        .op_b          (op_b),
        .alu_operation (alu_operation),
        .alu_in_x      (alu_in_x),
        .alu_in_y      (alu_in_y),
        .alu_out_s     (alu_out_s),
        .alu_zr        (alu_zr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .branch_taken  (branch_taken),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_out_s = '0;
        case (alu_operation)
            4'b0000: alu_out_s = alu_in_x & alu_in_y;
            4'b0001: alu_out_s = alu_in_x | alu_in_y;
            4'b0010: alu_out_s = alu_in_x + alu_in_y;
            4'b0011: alu_out_s = alu_in_x ^ alu_in_y;
            4'b0100: alu_out_s = alu_in_x << alu_in_y[4:0];
            4'b0101: alu_out_s = alu_in_x >> alu_in_y[4:0];
            4'b0110: alu_out_s = alu_in_x - alu_in_y;
            4'b0111: alu_out_s = {31'b0, $signed(alu_in_x) < $signed(alu_in_y)};
            4'b1000: alu_out_s = $unsigned($signed(alu_in_x) >>> alu_in_y[4:0]);
            4'b1001: alu_out_s = {31'b0, alu_in_x < alu_in_y};
            4'b1100: alu_out_s = ~(alu_in_x | alu_in_y);
            default: alu_out_s = '0;
        endcase
        alu_zr = (alu_out_s == 32'b0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request in IDLE and steps past the accepting edge.
    task automatic issue(input logic [1:0] t, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b);
        alu_op_type = t;
        funct3      = f3;
        funct7_5    = f7;
        op_a        = a;
        op_b        = b;
        in_valid    = 1'b1;
        tick();
        in_valid    = 1'b0;
    endtask

    // Called right after accept: EXEC has no response, DONE has one by edge N+2.
    task automatic expect_resp(input string tag, input logic [3:0] op, input logic [31:0] res,
                               input logic tkn, input logic ill);
        chk({tag, ".exec_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, ".exec_ready"}, {31'b0, in_ready}, 32'd0);
        chk({tag, ".op"}, {28'b0, alu_operation}, {28'b0, op});
        tick();
        tick();
        chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, ".result"}, result, res);
        chk({tag, ".taken"}, {31'b0, branch_taken}, {31'b0, tkn});
        chk({tag, ".illegal"}, {31'b0, illegal}, {31'b0, ill});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".idle_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, ".idle_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        #12;
        chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.op", {28'b0, alu_operation}, 32'd0);
        chk("rst.illegal", {31'b0, illegal}, 32'd0);
        chk("rst.taken", {31'b0, branch_taken}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        issue(2'b10, 3'b000, 1'b0, 32'd2565, 32'd1560);
        chk("add.x", alu_in_x, 32'd2565);
        chk("add.y", alu_in_y, 32'd1560);
        expect_resp("add", 4'b0010, 32'd4125, 1'b0, 1'b0);

        issue(2'b10, 3'b000, 1'b1, 32'd2565, 32'd3560);
        expect_resp("sub", 4'b0110, 32'hFFFF_FC1D, 1'b0, 1'b0);

        issue(2'b01, 3'b000, 1'b0, 32'd7, 32'd7);
        expect_resp("beq", 4'b0110, 32'd0, 1'b1, 1'b0);
        issue(2'b01, 3'b001, 1'b0, 32'd7, 32'd7);
        expect_resp("bne", 4'b0110, 32'd0, 1'b0, 1'b0);
        issue(2'b01, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1);
        expect_resp("blt", 4'b0111, 32'd1, 1'b1, 1'b0);
        issue(2'b01, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1);
        expect_resp("bltu", 4'b1001, 32'd0, 1'b0, 1'b0);

        issue(2'b11, 3'b101, 1'b1, 32'h8000_0000, 32'd4);
        expect_resp("srai", 4'b1000, 32'hF800_0000, 1'b0, 1'b0);
        issue(2'b00, 3'b111, 1'b1, 32'd100, 32'd23);
        expect_resp("mem", 4'b0010, 32'd123, 1'b0, 1'b0);

        // Backpressure: a second request waits while DONE is stalled.
        issue(2'b11, 3'b000, 1'b1, 32'd10, 32'd20);
        chk("bp.op", {28'b0, alu_operation}, 32'd2);
        tick();
        tick();
        alu_op_type = 2'b10;
        funct3      = 3'b100;
        funct7_5    = 1'b0;
        op_a        = 32'h0000_F0F0;
        op_b        = 32'h0000_0FF0;
        in_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp.valid", {31'b0, out_valid}, 32'd1);
            chk("bp.ready", {31'b0, in_ready}, 32'd0);
            chk("bp.result", result, 32'd30);
            tick();
        end
        chk("bp.held_op", {28'b0, alu_operation}, 32'd2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp.idle_ready", {31'b0, in_ready}, 32'd1);
        chk("bp.idle_valid", {31'b0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("bp2.x", alu_in_x, 32'h0000_F0F0);
        expect_resp("bp2", 4'b0011, 32'h0000_FF00, 1'b0, 1'b0);

        issue(2'b10, 3'b110, 1'b1, 32'd5, 32'd3);
        chk("ill_r.y", alu_in_y, 32'd3);
        expect_resp("ill_r", 4'b0000, 32'd0, 1'b0, 1'b1);
        issue(2'b01, 3'b010, 1'b0, 32'd9, 32'd9);
        expect_resp("ill_b", 4'b0000, 32'd0, 1'b0, 1'b1);

        // Reset in the EXEC cycle must abort without a response.
        issue(2'b10, 3'b000, 1'b0, 32'd40, 32'd2);
        chk("abort.exec_ready", {31'b0, in_ready}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("abort.valid", {31'b0, out_valid}, 32'd0);
        chk("abort.ready", {31'b0, in_ready}, 32'd1);
        chk("abort.result", result, 32'd0);
        tick();
        chk("abort.still_valid", {31'b0, out_valid}, 32'd0);
        reset = 1'b0;
        tick();
        issue(2'b10, 3'b000, 1'b0, 32'd1, 32'd2);
        expect_resp("post_rst", 4'b0010, 32'd3, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
